// File: rtl/led_blinker_pkg.sv
// Shared types and default timing for the LED blinker and its board wrapper.
// The defaults give a 1 s blink, 0.5 s dark and a 2 s gap at 50 MHz.
package led_blinker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int DEFAULT_ON_CYCLES  = 50_000_000;
    localparam int DEFAULT_OFF_CYCLES = 25_000_000;
    localparam int DEFAULT_GAP_CYCLES = 100_000_000;
    localparam int DEFAULT_CNT_W      = 4;
    localparam int DEFAULT_TIMER_W    = 27;

endpackage

// File: rtl/blink_timer.sv
// Phase timer: a down-counter that is loaded on phase entry and holds at zero.
// The expired output is high while the count reads zero.
module blink_timer #(
    parameter int TIMER_W = 27
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               expired
);

    logic [TIMER_W-1:0] value;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - TIMER_W'(1);
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/led_blinker.sv
// Turns a one-cycle request strobe into N blinks on an active-low LED pin,
// with a one-deep queue for a request that arrives while a sequence runs.
module led_blinker
    import led_blinker_pkg::*;
#(
    parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
    parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int TIMER_W    = DEFAULT_TIMER_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             trigger,
    input  logic [CNT_W-1:0] blink_count,
    output logic             led_n,
    output logic             busy,
    output logic             pending,
    output logic             dropped
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   queued;
    logic               expired;
    logic               start_req;
    logic               accept_direct;
    logic               take_queue;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;

    assign start_req     = trigger && (blink_count != '0);
    assign accept_direct = (state == ST_IDLE) && !pending && start_req;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        take_queue = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pending) begin
                    state_nxt  = ST_ON;
                    take_queue = 1'b1;
                end else if (start_req) begin
                    state_nxt = ST_ON;
                end
            end
            ST_ON: begin
                if (expired) state_nxt = ST_OFF;
            end
            ST_OFF: begin
                if (expired) state_nxt = (remaining == CNT_W'(1)) ? ST_GAP : ST_ON;
            end
            ST_GAP: begin
                if (expired) begin
                    if (pending) begin
                        state_nxt  = ST_ON;
                        take_queue = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Every transition changes state, so a state change marks phase entry.
    always_comb begin
        timer_load  = (state_nxt != state);
        timer_value = '0;
        unique case (state_nxt)
            ST_ON:   timer_value = TIMER_W'(ON_CYCLES - 1);
            ST_OFF:  timer_value = TIMER_W'(OFF_CYCLES - 1);
            ST_GAP:  timer_value = TIMER_W'(GAP_CYCLES - 1);
            default: timer_value = '0;
        endcase
    end

    blink_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            queued    <= '0;
            pending   <= 1'b0;
            led_n     <= 1'b1;
            busy      <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            state   <= state_nxt;
            led_n   <= (state_nxt != ST_ON);
            busy    <= (state_nxt != ST_IDLE);
            dropped <= 1'b0;

            if (accept_direct) begin
                remaining <= blink_count;
            end else if (take_queue) begin
                remaining <= queued;
            end else if ((state == ST_OFF) && expired) begin
                remaining <= remaining - CNT_W'(1);
            end

            if (take_queue) pending <= 1'b0;

            // A held request blocks the queue until it is consumed; extras are reported.
            if (start_req && !accept_direct) begin
                if (!pending) begin
                    queued  <= blink_count;
                    pending <= 1'b1;
                end else begin
                    dropped <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_blinker.sv
// Directed bench for led_blinker with short phases (ON=4, OFF=3, GAP=6);
// each scenario compares all four outputs every cycle against hand-derived windows.
module tb_led_blinker;

    localparam int ON      = 4;
    localparam int OFF     = 3;
    localparam int GAP     = 6;
    localparam int CNT_W   = 4;
    localparam int TIMER_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             trigger;
    logic [CNT_W-1:0] blink_count;
    logic             led_n;
    logic             busy;
    logic             pending;
    logic             dropped;

    int n_cmp = 0;
    int n_bad = 0;

    led_blinker #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .GAP_CYCLES (GAP),
        .CNT_W      (CNT_W),
        .TIMER_W    (TIMER_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .trigger     (trigger),
        .blink_count (blink_count),
        .led_n       (led_n),
        .busy        (busy),
        .pending     (pending),
        .dropped     (dropped)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Holds reset for three cycles, then runs cycles 0..last of scenario id.
    task automatic run_test(input int id, input int last);
        logic exp_lit, exp_busy, exp_pend, exp_drop;
        reset       = 1'b1;
        trigger     = 1'b0;
        blink_count = '0;
        repeat (3) @(posedge clock);
        #1;
        for (int c = 0; c <= last; c++) begin
            reset       = 1'b0;
            trigger     = 1'b0;
            blink_count = '0;
            unique case (id)
                1: if (c == 10) begin trigger = 1'b1; blink_count = 4'd2; end
                2: if (c == 10) begin trigger = 1'b1; blink_count = 4'd0; end
                3, 4: begin
                    if (c == 10) begin trigger = 1'b1; blink_count = 4'd2; end
                    if (c == 16) begin trigger = 1'b1; blink_count = 4'd1; end
                    if (id == 4 && c == 20) begin trigger = 1'b1; blink_count = 4'd5; end
                end
                5: begin
                    if (c == 10) begin trigger = 1'b1; blink_count = 4'd3; end
                    if (c == 13) reset = 1'b1;
                end
                6: if (c == 10) begin trigger = 1'b1; blink_count = 4'd2; reset = 1'b1; end
                default: ;
            endcase

            exp_lit  = 1'b0;
            exp_busy = 1'b0;
            exp_pend = 1'b0;
            exp_drop = 1'b0;
            unique case (id)
                1: begin
                    exp_lit  = in_rng(c, 11, 14) || in_rng(c, 18, 21);
                    exp_busy = in_rng(c, 11, 30);
                end
                3, 4: begin
                    exp_lit  = in_rng(c, 11, 14) || in_rng(c, 18, 21) || in_rng(c, 31, 34);
                    exp_busy = in_rng(c, 11, 43);
                    exp_pend = in_rng(c, 17, 30);
                    exp_drop = (id == 4) && (c == 21);
                end
                5: begin
                    exp_lit  = in_rng(c, 11, 13);
                    exp_busy = in_rng(c, 11, 13);
                end
                default: ;
            endcase

            @(negedge clock);
            check($sformatf("t%0d c%0d led_n", id, c), led_n, !exp_lit);
            check($sformatf("t%0d c%0d busy", id, c), busy, exp_busy);
            check($sformatf("t%0d c%0d pending", id, c), pending, exp_pend);
            check($sformatf("t%0d c%0d dropped", id, c), dropped, exp_drop);
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        run_test(1, 36);
        run_test(2, 20);
        run_test(3, 48);
        run_test(4, 48);
        run_test(5, 30);
        run_test(6, 24);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
